routex_tx_buf: RTL and testbench
================================

Name: routex_tx_buf

Overview:
- Transmit-side packet buffer for the routex link; it is the sending counterpart of routex_rx_buf.
- Accepts one header and a stream of 64-bit payload words from the local source.
- Stores the whole packet (store-and-forward), then emits it as contiguous 8-lane x 64-bit beats on the link.
- Beat order: one header beat, then the packed payload beats, with D_VALID/Q_VALID held high for the whole packet.

Parameters:
- MAX_BEATS, 32, payload buffer depth in 512-bit beats; MAX_WORDS = 8*MAX_BEATS (256).
- LEN_W, 16, width of the LEN input.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- HDR  in  [6:0][63:0]  route words for header lanes 0..6; sampled on accepted START.
- LEN  in  LEN_W  payload length in 64-bit words; sampled on accepted START.
- START  in  1  packet request; accepted when START&READY.
- READY  out  1  block idle, can accept START.
- W_D  in  64  payload word.
- W_VALID  in  1  payload word valid.
- W_READY  out  1  block accepting payload words.
- ERR  out  1  one-cycle pulse: START rejected because LEN > MAX_WORDS.
- Q  out  [7:0][63:0]  link beat.
- Q_VALID  out  1  link beat valid.
- Q_BP  in  1  link backpressure; blocks the start of a packet only.

Behaviour:
- Reset (async, RST=1):
  - State IDLE; READY=0 while RST is high; W_READY=0, ERR=0, Q=0, Q_VALID=0.
  - Word counter and beat counter cleared.
  - A partial or in-flight packet is discarded; no further beats are sent after RST deasserts.
- FSM states: IDLE, LOAD, WAIT, SEND.
- IDLE:
  - READY=1 (combinational from state).
  - START with LEN > MAX_WORDS: ERR pulses on the next cycle and the state stays IDLE.
  - START with LEN=0: latch HDR/LEN and go to WAIT.
  - START with any other length: latch HDR/LEN, clear the word counter, go to LOAD.
- LOAD:
  - W_READY=1.
  - Each W_VALID cycle writes W_D to buffer beat cnt[..:3], lane cnt[2:0], then cnt++.
  - On the cycle the word with cnt==LEN-1 is accepted, go to WAIT.
  - W_VALID gaps are allowed. START is ignored (READY=0).
- WAIT:
  - While Q_BP=1, hold.
  - At the first edge with Q_BP=0: Q <= header beat, Q_VALID <= 1, go to SEND.
  - Header beat: lanes 0..6 = latched HDR, lane 7 = LEN zero-extended to 64 bits.
- SEND:
  - One payload beat per cycle, NB = ceil(LEN/8) beats, back to back.
  - Q_BP is ignored once the header has been sent; the packet is never split.
  - Lanes of the last beat beyond LEN are driven 0.
  - After the last beat (or directly after the header when LEN=0), the next edge drives Q_VALID <= 0, Q <= 0 and returns to IDLE.
- Latency:
  - Last word accepted at edge t: WAIT from t; header valid after edge t+1 if Q_BP=0.
  - Link occupancy is exactly 1+NB cycles.
  - IDLE is reached one cycle after the last beat; a new START is accepted on that cycle.
- Whenever Q_VALID=0, Q is 0.
- Counters are sized for MAX_WORDS.
- LEN == MAX_WORDS is legal and fills the buffer exactly.
- The buffer never wraps: one packet in flight at a time.

Test Plan:
- Nominal packet:
  - HDR lanes 0..2 = {8'h2,56'h0}, lane 3 = {8'h1,56'h1}, lanes 4..6 = {8'h1,56'h0}; LEN=10; words 64'h1..64'h8, 64'h9, 64'h10; Q_BP=0.
  - Required: three consecutive Q_VALID cycles.
  - Beat 0 = header with lane 7 = 10.
  - Beat 1 lanes 0..7 = 1..8.
  - Beat 2 lanes 0..1 = 9, 64'h10, lanes 2..7 = 0.
  - Then Q_VALID=0 and READY=1.
- Backpressure:
  - Same packet with Q_BP=1 held for 20 cycles after loading.
  - Required: Q_VALID stays 0 for those 20 cycles; header appears the cycle after Q_BP falls.
  - Asserting Q_BP during SEND does not stall or gap the beats.
- Boundaries:
  - LEN=0 → a single header beat with lane 7 = 0, Q_VALID high for 1 cycle.
  - LEN=8 → exactly 2 beats.
  - LEN=256 → 33 contiguous beats.
  - LEN=257 → ERR pulses 1 cycle, no Q_VALID, READY stays 1.
- Gapped input:
  - LEN=10 with W_VALID toggling every other cycle.
  - Required: same Q contents as the nominal packet; no beat is emitted before all 10 words are in.
- Reset mid-operation:
  - RST asserted after 5 of 10 words are loaded, and separately during beat 1 of SEND.
  - Required: Q_VALID=0 and Q=0 immediately (asynchronous).
  - After release: READY=1 and no residual beats; a following LEN=2 packet transmits correctly.

Source files
------------

// File: rtl/routex_tx_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : routex_tx_buf
// Purpose  : Transmit-side store-and-forward packet buffer for the routex
//            link. A header (7 route words + length) and a stream of 64-bit
//            payload words are captured, then the packet is emitted as one
//            header beat followed by ceil(LEN/8) packed 8-lane payload beats,
//            back to back, with Q_VALID held high for the whole packet.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK      in   1            clock
//   RST      in   1            asynchronous active-high reset
//   HDR      in   [6:0][63:0]  route words for header lanes 0..6
//   LEN      in   LEN_W        payload length in 64-bit words
//   START    in   1            packet request, accepted on START & READY
//   READY    out  1            idle, able to accept START
//   W_D      in   64           payload word
//   W_VALID  in   1            payload word valid
//   W_READY  out  1            payload words are being accepted
//   ERR      out  1            one-cycle pulse: START rejected, LEN too large
//   Q        out  [7:0][63:0]  link beat (all zero whenever Q_VALID is low)
//   Q_VALID  out  1            link beat valid
//   Q_BP     in   1            link backpressure, only delays the header beat
// ============================================================================
module routex_tx_buf #(
  parameter int MAX_BEATS = 32,
  parameter int LEN_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0][63:0] HDR,
  input  logic [LEN_W-1:0] LEN,
  input  logic             START,
  output logic             READY,
  input  logic [63:0]      W_D,
  input  logic             W_VALID,
  output logic             W_READY,
  output logic             ERR,
  output logic [7:0][63:0] Q,
  output logic             Q_VALID,
  input  logic             Q_BP
);

  localparam int MAX_WORDS = 8 * MAX_BEATS;
  // Word counter must reach MAX_WORDS, beat counter must reach MAX_BEATS.
  localparam int WCNT_W    = $clog2(MAX_WORDS + 1);
  localparam int BCNT_W    = $clog2(MAX_BEATS + 1);
  localparam int BADDR_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [6:0][63:0]   hdr_q,   hdr_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [BCNT_W-1:0]  nb_q,    nb_d;
  logic [WCNT_W-1:0]  wcnt_q,  wcnt_d;
  logic [BCNT_W-1:0]  bcnt_q,  bcnt_d;
  logic               err_q,   err_d;
  logic [7:0][63:0]   q_q,     q_d;
  logic               qv_q,    qv_d;

  // Payload storage, one entry per 8-lane beat. No reset: contents are only
  // ever read for lanes below the latched length of the current packet.
  logic [7:0][63:0]   buf_q [MAX_BEATS];

  logic               w_wr;
  logic               w_last_word;
  logic [LEN_W:0]     w_len_p7;
  logic [7:0][63:0]   w_beat;
  logic [7:0][63:0]   w_pay;
  logic [7:0][63:0]   w_hdr_beat;

  // --------------------------------------------------------------------------
  // Payload write port
  // --------------------------------------------------------------------------
  assign w_wr = (state_q == S_LOAD) && W_VALID;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      buf_q[wcnt_q[BADDR_W+2:3]][wcnt_q[2:0]] <= W_D;
    end
  end

  // --------------------------------------------------------------------------
  // Beat assembly
  // --------------------------------------------------------------------------
  // The last word is the one whose index equals LEN-1; LEN is never 0 in LOAD.
  assign w_last_word = (LEN_W'(wcnt_q) == (len_q - LEN_W'(1)));

  // ceil(LEN/8), computed one bit wider so LEN+7 cannot overflow.
  assign w_len_p7 = {1'b0, LEN} + (LEN_W+1)'(7);

  // The beat index is always below MAX_BEATS when it is used for a read.
  assign w_beat = buf_q[bcnt_q[BADDR_W-1:0]];

  // Lanes past the packet length carry stale data from earlier packets, so
  // they are forced to zero on the way out.
  for (genvar l = 0; l < 8; l++) begin : g_lane
    logic [BCNT_W+2:0] lane_idx;
    assign lane_idx = {bcnt_q, 3'(l)};
    assign w_pay[l] = (LEN_W'(lane_idx) < len_q) ? w_beat[l] : 64'd0;
  end

  always_comb begin
    w_hdr_beat      = '0;
    w_hdr_beat[6:0] = hdr_q;
    w_hdr_beat[7]   = 64'(len_q);
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      nb_q    <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      nb_q    <= nb_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    nb_d    = nb_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;
    q_d     = q_q;
    qv_d    = qv_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            hdr_d   = HDR;
            len_d   = LEN;
            nb_d    = BCNT_W'(w_len_p7 >> 3);
            wcnt_d  = '0;
            // An empty packet has nothing to load and goes straight to the
            // header stage.
            state_d = (LEN == '0) ? S_WAIT : S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (W_VALID) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (w_last_word) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Backpressure is only honoured here; once the header goes out the
        // packet is committed and runs to completion.
        if (!Q_BP) begin
          q_d     = w_hdr_beat;
          qv_d    = 1'b1;
          bcnt_d  = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (bcnt_q < nb_q) begin
          q_d    = w_pay;
          bcnt_d = bcnt_q + BCNT_W'(1);
        end else begin
          q_d     = '0;
          qv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // READY is gated by RST so no request can look accepted during reset.
  assign READY   = (state_q == S_IDLE) && !RST;
  assign W_READY = (state_q == S_LOAD);
  assign ERR     = err_q;
  assign Q       = q_q;
  assign Q_VALID = qv_q;

endmodule
`default_nettype wire

// File: tb/tb_routex_tx_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_routex_tx_buf
// Purpose  : Self-checking bench for routex_tx_buf. A vector table covers the
//            nominal, backpressure, gapped and boundary packets, hand-written
//            sequences cover reset in the middle of a load and of a send, and
//            a randomized loop runs packets against a reference model built
//            from the packet format (header beat, then 8 words per beat).
// Revision : 1.0  initial release
// ============================================================================
module tb_routex_tx_buf;

  localparam int MAX_BEATS = 32;
  localparam int LEN_W     = 16;
  localparam int MAX_WORDS = 8 * MAX_BEATS;

  logic             CLK = 1'b0;
  logic             RST;
  logic [6:0][63:0] HDR;
  logic [LEN_W-1:0] LEN;
  logic             START;
  logic             READY;
  logic [63:0]      W_D;
  logic             W_VALID;
  logic             W_READY;
  logic             ERR;
  logic [7:0][63:0] Q;
  logic             Q_VALID;
  logic             Q_BP;

  routex_tx_buf #(
    .MAX_BEATS (MAX_BEATS),
    .LEN_W     (LEN_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .HDR     (HDR),
    .LEN     (LEN),
    .START   (START),
    .READY   (READY),
    .W_D     (W_D),
    .W_VALID (W_VALID),
    .W_READY (W_READY),
    .ERR     (ERR),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_BP    (Q_BP)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Current packet as the model sees it.
  logic [63:0]      words [MAX_WORDS];
  logic [6:0][63:0] cur_hdr;
  int               cur_len;

  // Beats observed on the link and the cycle each one appeared in.
  logic [511:0] got[$];
  int           got_cyc[$];

  typedef struct {
    int len;
    bit gap;
    int bp;
    bit sbp;
    int exp_beats;
    bit exp_err;
    bit nominal;
  } vec_t;

  vec_t vt[11];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [511:0] act,
                          input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Link monitor: collect valid beats, and require an all-zero bus otherwise.
  always @(negedge CLK) begin
    if (!RST) begin
      if (Q_VALID) begin
        got.push_back(Q);
        got_cyc.push_back(cyc);
      end else begin
        chk_beat("q_zero_when_idle", Q, '0);
      end
    end
  end

  // Reference beat k of the current packet: beat 0 is the header, beat k>0
  // carries words 8*(k-1) .. 8*(k-1)+7, zero past the packet length.
  function automatic logic [511:0] model_beat(input int k);
    logic [7:0][63:0] b;
    int idx;
    b = '0;
    if (k == 0) begin
      for (int l = 0; l < 7; l++) b[l] = cur_hdr[l];
      b[7] = 64'(cur_len);
    end else begin
      for (int l = 0; l < 8; l++) begin
        idx = (k - 1) * 8 + l;
        if (idx < cur_len) b[l] = words[idx];
      end
    end
    return b;
  endfunction

  task automatic set_nominal();
    for (int l = 0; l < 3; l++) cur_hdr[l] = {8'h2, 56'h0};
    cur_hdr[3] = {8'h1, 56'h1};
    for (int l = 4; l < 7; l++) cur_hdr[l] = {8'h1, 56'h0};
    for (int i = 0; i < 9; i++) words[i] = 64'(i + 1);
    words[9] = 64'h10;
  endtask

  task automatic set_random();
    for (int l = 0; l < 7; l++) cur_hdr[l] = {$urandom, $urandom};
    for (int i = 0; i < MAX_WORDS; i++) words[i] = {$urandom, $urandom};
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_start();
    int g;
    g = 0;
    while (!READY && g < 50) begin
      @(posedge CLK); #1;
      g++;
    end
    chk_int("ready_before_start", int'(READY), 1);
    got.delete();
    got_cyc.delete();
    HDR   = cur_hdr;
    LEN   = LEN_W'(cur_len);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic load_words(input int n, input bit gap);
    int   idx;
    int   g;
    logic wr;
    idx = 0;
    g   = 0;
    while (idx < n && g < 4 * MAX_WORDS + 50) begin
      W_VALID = gap ? g[0] : 1'b1;
      W_D     = words[idx];
      wr      = W_READY;
      @(posedge CLK); #1;
      if (W_VALID && wr) idx++;
      g++;
    end
    W_VALID = 1'b0;
    chk_int("load_done", idx, n);
  endtask

  task automatic run_vec(input string name, input int len, input bit gap,
                         input int bp, input bit sbp, input int exp_beats,
                         input bit exp_err);
    int rel;
    int g;
    int n;
    cur_len = len;
    Q_BP    = (bp > 0);
    do_start();
    if (exp_err) begin
      chk_int({name, ":err_pulse"}, int'(ERR), 1);
      chk_int({name, ":ready_on_err"}, int'(READY), 1);
      @(posedge CLK); #1;
      chk_int({name, ":err_one_cycle"}, int'(ERR), 0);
      repeat (4) begin @(posedge CLK); #1; end
      chk_int({name, ":no_beats_on_err"}, got.size(), 0);
      chk_int({name, ":ready_after_err"}, int'(READY), 1);
      Q_BP = 1'b0;
    end else begin
      load_words(len, gap);
      chk_int({name, ":no_early_beat"}, got.size(), 0);
      if (bp > 0) begin
        repeat (bp) begin @(posedge CLK); #1; end
        chk_int({name, ":bp_hold"}, got.size(), 0);
        Q_BP = 1'b0;
      end
      rel = cyc;
      if (sbp) begin
        @(posedge CLK); #1;
        Q_BP = 1'b1;
      end
      g = 0;
      while (got.size() < exp_beats && g < exp_beats + 10) begin
        @(posedge CLK); #1;
        g++;
      end
      repeat (3) begin @(posedge CLK); #1; end
      Q_BP = 1'b0;
      n = got.size();
      chk_int({name, ":beat_count"}, n, exp_beats);
      if (n == exp_beats && n > 0) begin
        chk_int({name, ":hdr_latency"}, got_cyc[0], rel + 1);
        chk_int({name, ":contiguous"}, got_cyc[n-1] - got_cyc[0], n - 1);
        for (int k = 0; k < n; k++)
          chk_beat($sformatf("%s:beat%0d", name, k), got[k], model_beat(k));
      end
      chk_int({name, ":ready_after"}, int'(READY), 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int g;
    int len;
    bit err;

    //            len  gap bp  sbp beats err nominal
    vt[0]  = '{ 10,   0,  0,  0,  3,    0,  1 };  // nominal
    vt[1]  = '{ 10,   0,  20, 1,  3,    0,  1 };  // backpressure, BP during SEND
    vt[2]  = '{ 10,   1,  0,  0,  3,    0,  1 };  // gapped input
    vt[3]  = '{ 0,    0,  0,  0,  1,    0,  0 };  // header only
    vt[4]  = '{ 8,    0,  0,  0,  2,    0,  0 };  // exactly one payload beat
    vt[5]  = '{ 256,  0,  0,  0,  33,   0,  0 };  // full buffer
    vt[6]  = '{ 257,  0,  0,  0,  0,    1,  0 };  // one over the limit
    vt[7]  = '{ 1,    0,  0,  1,  2,    0,  0 };
    vt[8]  = '{ 9,    1,  3,  0,  3,    0,  0 };
    vt[9]  = '{ 255,  0,  2,  1,  33,   0,  0 };
    vt[10] = '{ 65535, 0, 0,  0,  0,    1,  0 };

    RST     = 1'b1;
    START   = 1'b0;
    W_VALID = 1'b0;
    W_D     = '0;
    HDR     = '0;
    LEN     = '0;
    Q_BP    = 1'b0;
    cur_hdr = '0;
    cur_len = 0;

    @(posedge CLK); #1;
    chk_int("rst_ready", int'(READY), 0);
    chk_int("rst_w_ready", int'(W_READY), 0);
    chk_int("rst_err", int'(ERR), 0);
    chk_int("rst_q_valid", int'(Q_VALID), 0);
    chk_beat("rst_q", Q, '0);
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
    #1;
    chk_int("ready_after_rst", int'(READY), 1);
    @(posedge CLK); #1;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].nominal) set_nominal();
      else set_random();
      run_vec($sformatf("vec%0d", i), vt[i].len, vt[i].gap, vt[i].bp,
              vt[i].sbp, vt[i].exp_beats, vt[i].exp_err);
    end

    // Reset after 5 of 10 words have been loaded.
    set_nominal();
    cur_len = 10;
    Q_BP    = 1'b0;
    do_start();
    load_words(5, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk_int("rstload_q_valid", int'(Q_VALID), 0);
    chk_beat("rstload_q", Q, '0);
    chk_int("rstload_ready", int'(READY), 0);
    chk_int("rstload_w_ready", int'(W_READY), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    chk_int("rstload_no_beats", got.size(), 0);
    chk_int("rstload_ready_after", int'(READY), 1);

    // Reset while the first payload beat is on the link.
    set_nominal();
    cur_len = 10;
    do_start();
    load_words(10, 1'b0);
    g = 0;
    while (got.size() < 1 && g < 10) begin
      @(posedge CLK); #1;
      g++;
    end
    chk_int("rstsend_beat1_valid", int'(Q_VALID), 1);
    chk_beat("rstsend_beat1", Q, model_beat(1));
    n0 = got.size();
    #2 RST = 1'b1;
    #1;
    chk_int("rstsend_q_valid", int'(Q_VALID), 0);
    chk_beat("rstsend_q", Q, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    chk_int("rstsend_no_residual", got.size(), n0);
    chk_int("rstsend_ready_after", int'(READY), 1);

    set_random();
    run_vec("post_rst_len2", 2, 1'b0, 0, 1'b0, 2, 1'b0);

    // Randomized packets, expected beat count from ceil(len/8)+1.
    for (int i = 0; i < 20; i++) begin
      set_random();
      if ($urandom_range(0, 9) == 0) len = int'($urandom_range(257, 400));
      else len = int'($urandom_range(0, 256));
      err = (len > MAX_WORDS);
      run_vec($sformatf("rnd%0d", i), len, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
              err ? 0 : 1 + (len + 7) / 8, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
